// File: rtl/ireg_wavefront_pkg.sv
// Shared types and helpers for the input-register wavefront controller.
//   state_e       : controller state encoding
//   LEN_ZERO_CODE : i_len value that stands for the maximum length 2^CNT_W
//   t_width()     : run-counter width that never wraps at max length + max skew
package ireg_wavefront_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_e;

    localparam int unsigned LEN_ZERO_CODE = 0;

    function automatic int unsigned t_width(input int unsigned cnt_w, input int unsigned rows);
        return cnt_w + $clog2(rows) + 1;
    endfunction

endpackage

// File: rtl/ireg_wavefront_row.sv
// Window comparator for one buffer row: enable is high while the run counter
// lies in [ROW, ROW+len-1]. Output is registered.
//   clk, rst_n : clock, synchronous active-low reset
//   run_i      : controller will be in RUN next cycle
//   t_i        : next-cycle run counter value
//   len_i      : effective stream length (1 .. 2^CNT_W)
//   en_o       : registered row enable
module ireg_wavefront_row #(
    parameter int unsigned ROW   = 0,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned T_W   = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic [T_W-1:0]   t_i,
    input  logic [CNT_W:0]   len_i,
    output logic             en_o
);

    logic lower_ok;
    logic upper_ok;
    logic en_d;
    logic en_q;

    // Row 0 has no lower bound; avoids a constant comparison against zero.
    if (ROW == 0) begin : g_first
        assign lower_ok = 1'b1;
    end else begin : g_rest
        assign lower_ok = (t_i >= T_W'(ROW));
    end

    assign upper_ok = (t_i < (T_W'(ROW) + T_W'(len_i)));
    assign en_d     = run_i && lower_ok && upper_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_d;
        end
    end

    assign en_o = en_q;

endmodule

// File: rtl/ireg_wavefront_ctrl.sv
// Wavefront controller for one column of horizontal input buffers.
// Per tile: one clear cycle to all rows, then a skewed enable window of
// len_eff cycles per row, row r lagging row 0 by r cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   i_start    : start request; accepted when i_start && o_ready
//   o_ready    : combinational, IDLE and no abort
//   i_len      : stream length, 0 encodes 2^CNT_W; latched on accept
//   i_abort    : abort current tile; forces a one-cycle clear
//   o_en       : per-row buffer enable (registered)
//   o_clr      : per-row buffer clear (registered)
//   o_busy     : high during CLEAR and RUN (registered)
//   o_done     : one-cycle pulse after normal completion (registered)
module ireg_wavefront_ctrl
    import ireg_wavefront_pkg::*;
#(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    output logic             o_ready,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_abort,
    output logic [ROWS-1:0]  o_en,
    output logic [ROWS-1:0]  o_clr,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned T_W = t_width(CNT_W, ROWS);
    localparam int unsigned L_W = CNT_W + 1;
    localparam logic [L_W-1:0] LEN_MAX = {1'b1, {CNT_W{1'b0}}};

    state_e          state_q, state_d;
    logic [T_W-1:0]  t_q, t_d;
    logic [L_W-1:0]  len_q, len_d;
    logic [ROWS-1:0] clr_q, clr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            run_next;
    logic            accept;
    logic            last_run;
    logic [L_W-1:0]  len_in_eff;

    assign o_ready    = (state_q == IDLE) && !i_abort;
    assign accept     = i_start && o_ready;
    assign len_in_eff = (i_len == CNT_W'(LEN_ZERO_CODE)) ? LEN_MAX : {1'b0, i_len};

    // Last RUN cycle: the last row's window closes at t = len_eff + ROWS - 2.
    assign last_run = (state_q == RUN) && (t_q == (T_W'(len_q) + T_W'(ROWS - 2)));

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            len_q   <= '0;
            clr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            len_q   <= len_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and counter logic; abort overrides everything.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        len_d   = len_q;
        if (i_abort) begin
            state_d = IDLE;
            t_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = CLEAR;
                        len_d   = len_in_eff;
                        t_d     = '0;
                    end
                end
                CLEAR: begin
                    state_d = RUN;
                    t_d     = '0;
                end
                RUN: begin
                    if (last_run) begin
                        state_d = IDLE;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + T_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    t_d     = '0;
                end
            endcase
        end
    end

    // Output decode from the next state, registered above.
    always_comb begin
        clr_d    = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        run_next = 1'b0;
        if (i_abort || (state_d == CLEAR)) begin
            clr_d = '1;
        end
        busy_d   = (state_d != IDLE);
        run_next = (state_d == RUN);
        done_d   = last_run && !i_abort;
    end

    for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
        ireg_wavefront_row #(
            .ROW   (r),
            .CNT_W (CNT_W),
            .T_W   (T_W)
        ) u_row (
            .clk   (clk),
            .rst_n (rst_n),
            .run_i (run_next),
            .t_i   (t_d),
            .len_i (len_q),
            .en_o  (o_en[r])
        );
    end

    assign o_clr  = clr_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: doc/ireg_wavefront_ctrl.md
Name: ireg_wavefront_ctrl

Overview:
Sequences the enable/clear controls of one column of horizontal input buffers (ROWS rows) in the rate-coded systolic array. For each tile it issues a one-cycle clear to every row. It then opens a skewed enable window of i_len cycles per row, with row r delayed r cycles behind row 0, so operand bitstreams enter the array as a diagonal wavefront. A valid/ready start handshake, a busy flag, a done pulse and an abort input connect it to the tile scheduler above.

Parameters:
ROWS, 16, number of buffer rows driven (>=2)
CNT_W, 8, width of stream-length field; i_len=0 encodes 2^CNT_W cycles

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
i_start  input  1  start request (valid)
o_ready  output  1  start accepted when i_start && o_ready
i_len  input  CNT_W  stream cycles per row; sampled on accept; 0 means 2^CNT_W
i_abort  input  1  synchronous abort of the current tile
o_en  output  ROWS  per-row buffer enable
o_clr  output  ROWS  per-row buffer clear
o_busy  output  1  high in CLEAR and RUN
o_done  output  1  one-cycle pulse on normal completion

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-low on rst_n; sampled only at posedge clk. Reset forces state IDLE and all registers to zero.
- Reset values: o_en=0, o_clr=0, o_busy=0, o_done=0. o_ready=1 from the first cycle after reset, unless i_abort is high.
- o_en, o_clr, o_busy and o_done are registered. o_ready = (state==IDLE) && !i_abort is combinational.
- State machine:
  - IDLE -> CLEAR on accept.
  - CLEAR lasts exactly 1 cycle, then -> RUN.
  - RUN -> IDLE after len_eff+ROWS-1 cycles.
- Length latch: on accept, len_eff = (i_len==0) ? 2^CNT_W : i_len. Held in a CNT_W+1 bit register. Changes on i_len after accept are ignored.
- Timing, with the accept edge as cycle 0:
  - o_clr = all ones in cycle 1 only.
  - o_en all zero in cycle 1.
  - Run counter t = 0 in cycle 2, incrementing each cycle.
  - o_en[r] = 1 iff r <= t <= r+len_eff-1.
  - Row r is therefore enabled in cycles 2+r .. 1+r+len_eff.
- o_en and o_clr are never both high in the same row in the same cycle.
- Completion: last enable (row ROWS-1) is in cycle ROWS+len_eff. In cycle ROWS+len_eff+1:
  - state is IDLE; o_done=1 for that cycle only; o_busy=0; o_en=0; o_ready=1.
  - A start in that cycle is accepted (back-to-back tiles, no bubble beyond the CLEAR cycle).
- o_busy = 1 exactly in cycles 1 .. ROWS+len_eff.
- Abort, when i_abort=1 in any state:
  - next cycle: state IDLE, o_en=0, o_clr=all ones for exactly one cycle, o_busy=0, o_done=0;
  - run counter zeroed.
  - Abort in IDLE also produces the one-cycle clear.
  - Abort together with i_start: abort wins and the start is not accepted, since o_ready=0.
- i_start while busy is ignored; the requester must hold it.
- Reset mid-tile: the next cycle shows reset values. No done pulse, no clear pulse.
- Counter width T_W = CNT_W + clog2(ROWS) + 1, so there is no wrap for len_eff=2^CNT_W with the maximum row skew.
- Row windows must come from comparators on t, or an equivalent token shift register. Behaviour must match the formula above exactly.

Decomposition:
- Package ireg_wavefront_pkg:
  - state enum {IDLE, CLEAR, RUN};
  - function for T_W;
  - localparam encoding for the len=0 → 2^CNT_W rule.
- One sub-module, ireg_wavefront_row:
  - per-row window comparator;
  - inputs: t, row index (parameter), len_eff;
  - output: that row's registered enable;
  - instantiated ROWS times by generate.

Test Plan:
- ROWS=4, CNT_W=4, len=3, start at cycle 0 -> o_clr=4'hF in cycle 1; o_en[0] in cycles 2-4, o_en[3] in cycles 5-7; o_done at cycle 8; o_busy in cycles 1-7.
- Same config, len=0 -> o_en[0] in cycles 2-17, o_en[3] in cycles 5-20; o_done at cycle 21; no counter wrap.
- Back-to-back: start held high, len=1 -> second accept in the o_done cycle 6; second o_clr in cycle 7; o_en[0] in cycle 8.
- Abort in cycle 4 of a len=3 tile -> cycle 5: o_en=0, o_clr=4'hF, o_busy=0, no o_done; o_ready=1 in cycle 5.
- i_start and i_abort both high in IDLE -> not accepted; o_clr=4'hF next cycle; no busy.
- rst_n low at cycle 3 of a tile -> cycle 4: all outputs zero, o_ready=1, no o_done; a following start gives the normal timing.
